// File: rtl/mips_pkg.sv
// mips_pkg: shared load-type encodings, writeback state enum and helpers.
// Revision 1.0
`default_nettype none

package mips_pkg;

  localparam int RN_W = 5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LW   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LHU  = 3'd3;
  localparam logic [2:0] LD_LB   = 3'd4;
  localparam logic [2:0] LD_LBU  = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_READY   = 2'd2
  } wb_state_e;

  function automatic logic is_load(input logic [2:0] ldtype);
    return (ldtype >= LD_LW) && (ldtype <= LD_LBU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ldtype, input logic [1:0] addr_lo);
    return ((ldtype == LD_LW) && (addr_lo != 2'd0)) ||
           (((ldtype == LD_LH) || (ldtype == LD_LHU)) && addr_lo[0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// load_align: selects and extends the addressed word/halfword/byte of a read word.
// Revision 1.0
`default_nettype none

module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  ldtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  bsel;

  always_comb begin
    half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    bsel = rdata[7:0];
      2'd1:    bsel = rdata[15:8];
      2'd2:    bsel = rdata[23:16];
      default: bsel = rdata[31:24];
    endcase
    case (ldtype)
      LD_LH:   data = {{16{half[15]}}, half};
      LD_LHU:  data = {16'h0000, half};
      LD_LB:   data = {{24{bsel[7]}}, bsel};
      LD_LBU:  data = {24'h000000, bsel};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB register with load wait, alignment check and forwarding.
// Optional load timeout enabled by defining WB_LOAD_TIMEOUT_EN. Revision 1.0
`default_nettype none

module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic            m_wreg,
  input  logic [RN_W-1:0] m_rn,
  input  logic [31:0]     m_alu,
  input  logic [2:0]      m_ldtype,
  input  logic [1:0]      m_addr_lo,
  input  logic            flush,
  input  logic [31:0]     dmem_rdata,
  input  logic            dmem_rvalid,
  output logic [RN_W-1:0] wn,
  output logic [31:0]     d,
  output logic            we,
  output logic            fwd_valid,
  output logic [RN_W-1:0] fwd_rn,
  output logic [31:0]     fwd_data,
  output logic            ld_pending,
  output logic [RN_W-1:0] ld_pending_rn,
  output logic            misalign,
  output logic            ld_timeout
);

  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_timeout_range_chk
    $error("mem_wb_stage: TIMEOUT_CYC must be in 1..255");
  end

  wb_state_e       state_q, state_d;
  logic            wreg_q, wreg_d;
  logic [RN_W-1:0] rn_q, rn_d;
  logic [31:0]     result_q, result_d;
  logic [2:0]      ldtype_q, ldtype_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            misalign_q, misalign_d;
  logic            ld_timeout_q, ld_timeout_d;
  logic [31:0]     ld_data;
  logic            accept;
  logic            mis_in;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  load_align u_load_align (
    .ldtype  (ldtype_q),
    .addr_lo (addr_lo_q),
    .rdata   (dmem_rdata),
    .data    (ld_data)
  );

  assign m_ready = !flush && (state_q != ST_WAIT_LD);
  assign accept  = m_valid && m_ready;
  assign mis_in  = is_misaligned(m_ldtype, m_addr_lo);

  always_comb begin
    state_d      = state_q;
    wreg_d       = wreg_q;
    rn_d         = rn_q;
    result_d     = result_q;
    ldtype_d     = ldtype_q;
    addr_lo_d    = addr_lo_q;
    misalign_d   = 1'b0;
    ld_timeout_d = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_WAIT_LD: begin
        // flush squashes the load even if the data arrives in the same cycle
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (dmem_rvalid) begin
          state_d  = ST_READY;
          result_d = ld_data;
`ifdef WB_LOAD_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_EMPTY;
          ld_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        if (accept) begin
          wreg_d     = m_wreg && !mis_in;
          rn_d       = m_rn;
          result_d   = m_alu;
          ldtype_d   = m_ldtype;
          addr_lo_d  = m_addr_lo;
          misalign_d = mis_in;
          state_d    = (is_load(m_ldtype) && !mis_in) ? ST_WAIT_LD : ST_READY;
`ifdef WB_LOAD_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
        end else begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_EMPTY;
      wreg_q       <= 1'b0;
      rn_q         <= '0;
      result_q     <= 32'd0;
      ldtype_q     <= LD_NONE;
      addr_lo_q    <= 2'd0;
      misalign_q   <= 1'b0;
      ld_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wreg_q       <= wreg_d;
      rn_q         <= rn_d;
      result_q     <= result_d;
      ldtype_q     <= ldtype_d;
      addr_lo_q    <= addr_lo_d;
      misalign_q   <= misalign_d;
      ld_timeout_q <= ld_timeout_d;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
  assign ld_timeout = ld_timeout_q;
`else
  assign ld_timeout = 1'b0;
`endif

  assign we            = (state_q == ST_READY) && wreg_q && (rn_q != '0);
  assign wn            = rn_q;
  assign d             = result_q;
  assign fwd_valid     = we;
  assign fwd_rn        = wn;
  assign fwd_data      = d;
  assign ld_pending    = (state_q == ST_WAIT_LD) && wreg_q && (rn_q != '0);
  assign ld_pending_rn = rn_q;
  assign misalign      = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed literal checks plus randomized traffic against an
// entry-level reference model of the MEM/WB stage.
`default_nettype none

module tb_mem_wb_stage;

  localparam int TO_CYC = 4;

  logic        clk;
  logic        clrn;
  logic        m_valid;
  logic        m_ready;
  logic        m_wreg;
  logic [4:0]  m_rn;
  logic [31:0] m_alu;
  logic [2:0]  m_ldtype;
  logic [1:0]  m_addr_lo;
  logic        flush;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [4:0]  wn;
  logic [31:0] d;
  logic        we;
  logic        fwd_valid;
  logic [4:0]  fwd_rn;
  logic [31:0] fwd_data;
  logic        ld_pending;
  logic [4:0]  ld_pending_rn;
  logic        misalign;
  logic        ld_timeout;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_wreg        (m_wreg),
    .m_rn          (m_rn),
    .m_alu         (m_alu),
    .m_ldtype      (m_ldtype),
    .m_addr_lo     (m_addr_lo),
    .flush         (flush),
    .dmem_rdata    (dmem_rdata),
    .dmem_rvalid   (dmem_rvalid),
    .wn            (wn),
    .d             (d),
    .we            (we),
    .fwd_valid     (fwd_valid),
    .fwd_rn        (fwd_rn),
    .fwd_data      (fwd_data),
    .ld_pending    (ld_pending),
    .ld_pending_rn (ld_pending_rn),
    .misalign      (misalign),
    .ld_timeout    (ld_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one in-flight entry, described by what it holds.
  bit          ent_valid = 0;
  bit          ent_wait  = 0;
  bit          ent_wreg  = 0;
  logic [4:0]  ent_rn    = 0;
  logic [31:0] ent_val   = 0;
  logic [2:0]  ent_t     = 0;
  logic [1:0]  ent_lo    = 0;
  int          ent_waited = 0;
  bit          mis_pulse = 0;
  bit          to_pulse  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] lo,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
    case (t)
      3'd2:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd3:    return h;
      3'd4:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd5:    return b;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    ent_valid = 0; ent_wait = 0; ent_wreg = 0; ent_rn = 0; ent_val = 0;
    ent_t = 0; ent_lo = 0; ent_waited = 0; mis_pulse = 0; to_pulse = 0;
  endtask

  task automatic model_step();
    bit mis, ld;
    if (!clrn) begin
      model_reset();
      return;
    end
    mis_pulse = 0;
    to_pulse  = 0;
    if (ent_valid && ent_wait) begin
      if (flush) ent_valid = 0;
      else if (dmem_rvalid) begin
        ent_wait = 0;
        ent_val  = extract(ent_t, ent_lo, dmem_rdata);
      end else begin
        ent_waited++;
`ifdef WB_LOAD_TIMEOUT_EN
        if (ent_waited == TO_CYC) begin
          ent_valid = 0;
          to_pulse  = 1;
        end
`endif
      end
    end else if (m_valid && !flush) begin
      ld  = (m_ldtype >= 3'd1) && (m_ldtype <= 3'd5);
      mis = ((m_ldtype == 3'd1) && (m_addr_lo != 2'd0)) ||
            (((m_ldtype == 3'd2) || (m_ldtype == 3'd3)) && m_addr_lo[0]);
      ent_valid  = 1;
      ent_wait   = ld && !mis;
      ent_wreg   = m_wreg && !mis;
      ent_rn     = m_rn;
      ent_val    = m_alu;
      ent_t      = m_ldtype;
      ent_lo     = m_addr_lo;
      ent_waited = 0;
      mis_pulse  = mis;
    end else begin
      ent_valid = 0;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit e_we, e_ldp;
    e_we  = ent_valid && !ent_wait && ent_wreg && (ent_rn != 0);
    e_ldp = ent_valid && ent_wait && ent_wreg && (ent_rn != 0);
    chk("m_ready", 32'(m_ready), 32'(!flush && !(ent_valid && ent_wait)));
    chk("we", 32'(we), 32'(e_we));
    chk("wn", 32'(wn), 32'(ent_rn));
    chk("fwd_valid", 32'(fwd_valid), 32'(e_we));
    chk("fwd_rn", 32'(fwd_rn), 32'(ent_rn));
    if (e_we) begin
      chk("d", d, ent_val);
      chk("fwd_data", fwd_data, ent_val);
    end
    chk("ld_pending", 32'(ld_pending), 32'(e_ldp));
    chk("ld_pending_rn", 32'(ld_pending_rn), 32'(ent_rn));
    chk("misalign", 32'(misalign), 32'(mis_pulse));
    chk("ld_timeout", 32'(ld_timeout), 32'(to_pulse));
  end

  task automatic drive(input logic v, input logic w, input logic [4:0] rn,
                       input logic [31:0] alu, input logic [2:0] t, input logic [1:0] lo,
                       input logic f, input logic rv, input logic [31:0] rd);
    m_valid = v; m_wreg = w; m_rn = rn; m_alu = alu; m_ldtype = t; m_addr_lo = lo;
    flush = f; dmem_rvalid = rv; dmem_rdata = rd;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    idle();
    #2;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wn", 32'(wn), 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_ld_pending", 32'(ld_pending), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_ld_timeout", 32'(ld_timeout), 32'd0);
    tick(); tick();
    clrn = 1'b1;
    tick();

    // ALU op: one-cycle latency
    drive(1, 1, 5'd5, 32'h1234, 3'd0, 2'd0, 0, 0, 32'd0);
    #1 chk("alu_ready", 32'(m_ready), 32'd1);
    tick();
    idle();
    #1;
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_wn", 32'(wn), 32'd5);
    chk("alu_d", d, 32'h1234);
    chk("alu_ready2", 32'(m_ready), 32'd1);
    tick();

    // LB / LBU from byte 3, data after two WAIT_LD cycles
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 5'd7, 32'hDEAD, (k == 0) ? 3'd4 : 3'd5, 2'd3, 0, 0, 32'd0);
      tick();
      idle();
      #1;
      chk("lb_pend1", 32'(ld_pending), 32'd1);
      chk("lb_ready1", 32'(m_ready), 32'd0);
      tick();
      drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 1, 32'h80FFFFFF);
      #1;
      chk("lb_pend2", 32'(ld_pending), 32'd1);
      chk("lb_pend_rn", 32'(ld_pending_rn), 32'd7);
      tick();
      idle();
      #1;
      chk("lb_we", 32'(we), 32'd1);
      chk("lb_d", d, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
    end

    // LH misaligned, then LH / LHU aligned on the upper halfword
    drive(1, 1, 5'd8, 32'h55, 3'd2, 2'd1, 0, 0, 32'd0);
    tick();
    idle();
    #1;
    chk("lh_mis_pulse", 32'(misalign), 32'd1);
    chk("lh_mis_we", 32'(we), 32'd0);
    tick();
    drive(1, 1, 5'd8, 32'h55, 3'd2, 2'd2, 0, 0, 32'd0);
    tick();
    drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 1, 32'h7FFE0000);
    tick();
    idle();
    #1 chk("lh_d", d, 32'h00007FFE);
    tick();
    drive(1, 1, 5'd9, 32'h0, 3'd2, 2'd2, 0, 0, 32'd0);
    tick();
    drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 1, 32'h80011234);
    tick();
    idle();
    #1 chk("lh_sext_d", d, 32'hFFFF8001);
    tick();

    // rn = 0 never writes
    drive(1, 1, 5'd0, 32'hABCD, 3'd0, 2'd0, 0, 0, 32'd0);
    tick();
    idle();
    #1 chk("rn0_we", 32'(we), 32'd0);
    tick();

    // flush while waiting, then late rvalid is ignored
    drive(1, 1, 5'd9, 32'd0, 3'd1, 2'd0, 0, 0, 32'd0);
    tick();
    drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 0, 32'd0);
    tick();
    drive(0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 1, 32'h11111111);
    #1;
    chk("flush_we", 32'(we), 32'd0);
    chk("flush_ready", 32'(m_ready), 32'd1);
    tick();
    idle();
    #1 chk("flush_we2", 32'(we), 32'd0);
    tick();

    // asynchronous reset while READY
    drive(1, 1, 5'd3, 32'h77, 3'd0, 2'd0, 0, 0, 32'd0);
    tick();
    idle();
    #1 chk("arst_we_before", 32'(we), 32'd1);
    clrn = 1'b0;
    model_reset();
    #1 chk("arst_we_after", 32'(we), 32'd0);
    tick();
    clrn = 1'b1;
    tick();

`ifdef WB_LOAD_TIMEOUT_EN
    drive(1, 1, 5'd4, 32'd0, 3'd1, 2'd0, 0, 0, 32'd0);
    tick();
    idle();
    for (int c = 0; c < TO_CYC; c++) begin
      #1 chk("to_pending", 32'(ld_pending), 32'd1);
      tick();
    end
    #1;
    chk("to_pulse", 32'(ld_timeout), 32'd1);
    chk("to_we", 32'(we), 32'd0);
    chk("to_ready", 32'(m_ready), 32'd1);
    tick();
`endif

    // randomized traffic; flush and rvalid never coincide
    for (int i = 0; i < 2000; i++) begin
      logic f;
      f = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            f, f ? 1'b0 : ($urandom_range(0, 2) == 0), $urandom);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
